// File: rtl/wr_arbiter.sv
// Round-robin arbiter sharing one packet write path among N ports; grant is held
// per packet, header/data forwarded with one registered cycle and a length watchdog.
module wr_arbiter #(
  parameter int N       = 16,
  parameter int DW      = 16,
  parameter int MAX_LEN = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_req,
  input  logic [4*N-1:0]       in_dest,
  input  logic [3*N-1:0]       in_prior,
  input  logic [N-1:0]         in_vld,
  input  logic [N-1:0]         in_eop,
  input  logic [DW*N-1:0]      in_data,
  output logic [N-1:0]         in_rdy,
  input  logic                 out_ready,
  output logic [N-1:0]         gnt,
  output logic                 out_sop,
  output logic [3:0]           out_dest,
  output logic [2:0]           out_prior,
  output logic [$clog2(N)-1:0] out_port,
  output logic                 out_vld,
  output logic [DW-1:0]        out_data,
  output logic                 out_eop,
  output logic                 out_abort,
  output logic                 busy
);

  // state | meaning
  // IDLE  | waiting for a request while downstream is ready
  // XFER  | grant held, forwarding words until eop or watchdog
  // GAP   | one dead cycle, advance round-robin pointer
  localparam int PW = $clog2(N);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [9:0] LEN_LIM = 10'(MAX_LEN);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [9:0]    len_cnt_q, len_cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          sop_q, sop_d;
  logic [3:0]    dest_q, dest_d;
  logic [2:0]    prior_q, prior_d;
  logic [PW-1:0] port_q, port_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic          eop_q, eop_d;
  logic          abort_q, abort_d;

  logic [PW-1:0] sel;
  logic [PW-1:0] cand;
  logic          found;
  logic          xfer;
  logic          word_eop;
  logic          at_limit;

  // first requester at or after rr_ptr, wrapping mod N
  always_comb begin
    sel   = rr_ptr_q;
    cand  = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = rr_ptr_q + PW'(i);
      if (!found && in_req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign in_rdy   = gnt_q & {N{out_ready}};
  assign xfer     = (state_q == ST_XFER) && in_vld[port_q] && in_rdy[port_q];
  assign word_eop = in_eop[port_q];
  assign at_limit = (len_cnt_q + 10'd1) == LEN_LIM;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    len_cnt_d = len_cnt_q;
    gnt_d     = gnt_q;
    sop_d     = 1'b0;
    dest_d    = dest_q;
    prior_d   = prior_q;
    port_d    = port_q;
    vld_d     = 1'b0;
    data_d    = data_q;
    eop_d     = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|in_req && out_ready) begin
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          sop_d      = 1'b1;
          dest_d     = in_dest[4*sel +: 4];
          prior_d    = in_prior[3*sel +: 3];
          port_d     = sel;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer) begin
          vld_d     = 1'b1;
          data_d    = in_data[DW*port_q +: DW];
          len_cnt_d = len_cnt_q + 10'd1;
          // a real eop on the limit word is a normal end, not an abort
          if (word_eop || at_limit) begin
            eop_d   = 1'b1;
            abort_d = !word_eop;
            gnt_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        rr_ptr_d  = port_q + PW'(1);
        len_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      len_cnt_q <= '0;
      gnt_q     <= '0;
      sop_q     <= 1'b0;
      dest_q    <= '0;
      prior_q   <= '0;
      port_q    <= '0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      eop_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      len_cnt_q <= len_cnt_d;
      gnt_q     <= gnt_d;
      sop_q     <= sop_d;
      dest_q    <= dest_d;
      prior_q   <= prior_d;
      port_q    <= port_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      eop_q     <= eop_d;
      abort_q   <= abort_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_sop   = sop_q;
  assign out_dest  = dest_q;
  assign out_prior = prior_q;
  assign out_port  = port_q;
  assign out_vld   = vld_q;
  assign out_data  = data_q;
  assign out_eop   = eop_q;
  assign out_abort = abort_q;
  assign busy      = state_q != ST_IDLE;

endmodule

// File: tb/tb_wr_arbiter.sv
// Scoreboard bench for wr_arbiter: stimulus pushes expected headers/words,
// a negedge monitor pops and compares whenever the DUT emits them.
module tb_wr_arbiter;
  localparam int N    = 16;
  localparam int DW   = 16;
  localparam int MAXL = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_req = '0;
  logic [4*N-1:0]  in_dest = '0;
  logic [3*N-1:0]  in_prior = '0;
  logic [N-1:0]    in_vld = '0;
  logic [N-1:0]    in_eop = '0;
  logic [DW*N-1:0] in_data = '0;
  logic [N-1:0]    in_rdy;
  logic            out_ready = 1'b1;
  logic [N-1:0]    gnt;
  logic            out_sop;
  logic [3:0]      out_dest;
  logic [2:0]      out_prior;
  logic [3:0]      out_port;
  logic            out_vld;
  logic [DW-1:0]   out_data;
  logic            out_eop;
  logic            out_abort;
  logic            busy;

  wr_arbiter #(.N(N), .DW(DW), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_dest(in_dest), .in_prior(in_prior),
    .in_vld(in_vld), .in_eop(in_eop), .in_data(in_data), .in_rdy(in_rdy),
    .out_ready(out_ready), .gnt(gnt), .out_sop(out_sop), .out_dest(out_dest),
    .out_prior(out_prior), .out_port(out_port), .out_vld(out_vld), .out_data(out_data),
    .out_eop(out_eop), .out_abort(out_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dest;
    logic [2:0] prior;
    logic [3:0] port;
  } sop_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          eop;
    logic          abort;
  } word_t;

  sop_t  exp_sop[$];
  word_t exp_word[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      sop_t  es;
      word_t ew;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("eop_needs_vld", 32'(out_eop & ~out_vld), 32'd0);
      if (out_sop) begin
        if (exp_sop.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_sop: got port %0d expected none", out_port);
        end else begin
          es = exp_sop.pop_front();
          chk("sop_port", 32'(out_port), 32'(es.port));
          chk("sop_dest", 32'(out_dest), 32'(es.dest));
          chk("sop_prior", 32'(out_prior), 32'(es.prior));
          chk("sop_gnt", 32'(gnt), 32'(N'(1) << es.port));
        end
      end
      if (out_vld) begin
        if (exp_word.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got data %0h expected none", out_data);
        end else begin
          ew = exp_word.pop_front();
          chk("word_data", 32'(out_data), 32'(ew.data));
          chk("word_eop", 32'(out_eop), 32'(ew.eop));
          chk("word_abort", 32'(out_abort), 32'(ew.abort));
        end
        if (out_eop) chk("gnt_zero_in_gap", 32'(gnt), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_port(input int p, input logic [3:0] d, input logic [2:0] pr, input bit push);
    in_dest[4*p +: 4]  = d;
    in_prior[3*p +: 3] = pr;
    in_req[p]          = 1'b1;
    if (push) exp_sop.push_back('{d, pr, 4'(p)});
  endtask

  task automatic wait_gnt(input int p);
    int k = 0;
    while (!gnt[p] && k < 40) begin
      tick();
      k++;
    end
    chk($sformatf("gnt_port%0d", p), 32'(gnt), 32'(N'(1) << p));
  endtask

  task automatic send_pkt(input int p, input int nwords, input int eop_at,
                          input int stall_at, input logic [15:0] base);
    int i     = 1;
    int guard = 0;
    bit done  = 1'b0;
    bit eo, ab;
    while (i <= nwords && !done && guard < 60) begin
      in_vld[p]            = 1'b1;
      in_data[DW*p +: DW]  = base + 16'(i);
      in_eop[p]            = (i == eop_at);
      if (i == stall_at && out_ready) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("in_rdy_stall", 32'(in_rdy), 32'd0);
          tick();
        end
        out_ready = 1'b1;
      end
      #1;
      if (in_rdy[p]) begin
        eo = (i == eop_at) || (i == MAXL);
        ab = (i == MAXL) && (i != eop_at);
        exp_word.push_back('{base + 16'(i), eo, ab});
        done = eo;
        i++;
      end
      tick();
      guard++;
    end
    chk($sformatf("pkt_done_port%0d", p), 32'(done), 32'd1);
    while (i <= nwords) begin
      in_vld[p]           = 1'b1;
      in_data[DW*p +: DW] = base + 16'(i);
      in_eop[p]           = 1'b0;
      tick();
      i++;
    end
    in_vld[p] = 1'b0;
    in_eop[p] = 1'b0;
  endtask

  int order[5] = '{0, 2, 15, 0, 2};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_sop", 32'(out_sop), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // round robin over ports 0, 2, 15 with requests held
    req_port(0, 4'h5, 3'd1, 1'b0);
    req_port(2, 4'h7, 3'd3, 1'b0);
    req_port(15, 4'hA, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++)
      exp_sop.push_back('{4'(order[k]) ^ 4'h5,
                          (order[k] == 0) ? 3'd1 : (order[k] == 2) ? 3'd3 : 3'd0,
                          4'(order[k])});
    for (int k = 0; k < 5; k++) begin
      wait_gnt(order[k]);
      if (k == 4) in_req = '0;
      send_pkt(order[k], 1, 1, 0, 16'(16'h0100 * (k + 1)));
    end

    // single requester
    req_port(3, 4'hA, 3'd5, 1'b1);
    wait_gnt(3);
    in_req[3] = 1'b0;
    send_pkt(3, 4, 4, 0, 16'h3000);

    // backpressure; port 5 must win over 2 since rr_ptr is now 4
    req_port(5, 4'h3, 3'd6, 1'b1);
    req_port(2, 4'h9, 3'd2, 1'b1);
    wait_gnt(5);
    in_req[5] = 1'b0;
    send_pkt(5, 6, 6, 3, 16'h5000);
    wait_gnt(2);
    in_req[2] = 1'b0;
    send_pkt(2, 1, 1, 0, 16'h2000);

    // watchdog abort, then eop exactly on the limit word
    req_port(1, 4'hC, 3'd4, 1'b1);
    wait_gnt(1);
    in_req[1] = 1'b0;
    req_port(6, 4'h6, 3'd7, 1'b1);
    send_pkt(1, 12, 0, 0, 16'h1000);
    wait_gnt(6);
    in_req[6] = 1'b0;
    send_pkt(6, 8, 8, 0, 16'h6000);

    // reset during word 2
    req_port(9, 4'h2, 3'd2, 1'b1);
    wait_gnt(9);
    in_req[9] = 1'b0;
    in_vld[9] = 1'b1;
    in_data[DW*9 +: DW] = 16'h9001;
    #1;
    chk("rst_pkt_w1_rdy", 32'(in_rdy[9]), 32'd1);
    exp_word.push_back('{16'h9001, 1'b0, 1'b0});
    tick();
    in_data[DW*9 +: DW] = 16'h9002;
    #5;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_vld", 32'(out_vld), 32'd0);
    chk("midrst_eop", 32'(out_eop), 32'd0);
    chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
    chk("midrst_port", 32'(out_port), 32'd0);
    in_vld[9] = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    req_port(0, 4'h1, 3'd1, 1'b1);
    req_port(4, 4'h4, 3'd4, 1'b1);
    wait_gnt(0);
    in_req[0] = 1'b0;
    send_pkt(0, 2, 2, 0, 16'hA000);
    wait_gnt(4);
    in_req[4] = 1'b0;
    send_pkt(4, 1, 1, 0, 16'hB000);

    repeat (5) tick();
    chk("sop_queue_empty", 32'(exp_sop.size()), 32'd0);
    chk("word_queue_empty", 32'(exp_word.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
